// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator memory (cmem) channel.
package acc_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;

  localparam logic CMEM_STATUS_OK  = 1'b0;
  localparam logic CMEM_STATUS_ERR = 1'b1;

endpackage

// File: rtl/cmem_responder.sv
// Core-side cmem responder: takes one FPU load/store request, runs it on the
// OBI data port (or rejects/probes it locally) and returns one response beat.
module cmem_responder
  import acc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmem_q_valid_i,
  output logic                    cmem_q_ready_o,
  input  mem_req_type_e           cmem_q_req_type_i,
  input  logic [ADDR_WIDTH-1:0]   cmem_q_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmem_q_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmem_q_be_i,
  input  logic [ID_WIDTH-1:0]     cmem_q_id_i,
  input  logic                    cmem_q_mode_i,
  input  logic                    cmem_q_spec_i,
  input  logic                    cmem_q_endoftransaction_i,
  output logic                    cmem_p_valid_o,
  input  logic                    cmem_p_ready_i,
  output logic [DATA_WIDTH-1:0]   cmem_p_rdata_o,
  output logic [ID_WIDTH-1:0]     cmem_p_id_o,
  output logic                    cmem_p_status_o,
  output logic                    cmem_p_endoftransaction_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic                    data_we_o,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i,
  output logic                    busy_o
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int LSB = (BW > 1) ? $clog2(BW) : 1;
  localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS_REQ, S_BUS_WAIT, S_RESP} state_e;

  state_e                r_state;
  logic                  r_q_ready, r_p_valid, r_req, r_busy, r_we, r_status, r_eot;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [BW-1:0]         r_be;
  logic [ID_WIDTH-1:0]   r_id;
  logic [CW-1:0]         r_cnt;

  logic          w_misalign, w_reject, w_timeout;
  logic [CW-1:0] w_cnt_nxt;

  // Full-word accesses must be word aligned, halfword accesses halfword aligned.
  assign w_misalign = ((cmem_q_be_i == '1) && (cmem_q_addr_i[LSB-1:0] != '0)) ||
                      (($countones(cmem_q_be_i) == 2) && cmem_q_addr_i[0]);
  assign w_reject   = (cmem_q_spec_i && (cmem_q_req_type_i == WRITE)) ||
                      (cmem_q_be_i == '0) || w_misalign;

  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_q_ready <= 1'b1;
      r_p_valid <= 1'b0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_status  <= CMEM_STATUS_OK;
      r_eot     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_be      <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cmem_q_valid_i) begin
          r_q_ready <= 1'b0;
          r_busy    <= 1'b1;
          r_we      <= (cmem_q_req_type_i == WRITE);
          r_addr    <= cmem_q_addr_i;
          r_wdata   <= cmem_q_wdata_i;
          r_be      <= cmem_q_be_i;
          r_id      <= cmem_q_id_i;
          r_eot     <= cmem_q_endoftransaction_i;
          r_rdata   <= '0;
          if (cmem_q_mode_i) begin
            r_p_valid <= 1'b1;
            r_status  <= CMEM_STATUS_OK;
            r_state   <= S_RESP;
          end else if (w_reject) begin
            r_p_valid <= 1'b1;
            r_status  <= CMEM_STATUS_ERR;
            r_state   <= S_RESP;
          end else begin
            r_req   <= 1'b1;
            r_state <= S_BUS_REQ;
          end
        end
        S_BUS_REQ: if (data_gnt_i) begin
          r_req   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_BUS_WAIT;
        end
        S_BUS_WAIT: begin
          r_cnt <= w_cnt_nxt;
          // A response arriving on the timeout cycle still counts as a response.
          if (data_rvalid_i) begin
            r_p_valid <= 1'b1;
            r_status  <= data_err_i ? CMEM_STATUS_ERR : CMEM_STATUS_OK;
            r_rdata   <= (!r_we && !data_err_i) ? data_rdata_i : '0;
            r_state   <= S_RESP;
          end else if (w_timeout) begin
            r_p_valid <= 1'b1;
            r_status  <= CMEM_STATUS_ERR;
            r_rdata   <= '0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: if (cmem_p_ready_i) begin
          r_p_valid <= 1'b0;
          r_q_ready <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmem_q_ready_o            = r_q_ready;
  assign cmem_p_valid_o            = r_p_valid;
  assign cmem_p_rdata_o            = r_rdata;
  assign cmem_p_id_o               = r_id;
  assign cmem_p_status_o           = r_status;
  assign cmem_p_endoftransaction_o = r_eot;
  assign data_req_o                = r_req;
  assign data_we_o                 = r_we;
  assign data_addr_o               = r_addr;
  assign data_wdata_o              = r_wdata;
  assign data_be_o                 = r_be;
  assign busy_o                    = r_busy;

endmodule
